// File: rtl/commit_unit_pkg.sv
// commit_unit shared types: slot bundle, flush causes, FSM states.
// Widths are fixed here and shared by every commit-stage file.
package commit_unit_pkg;

  localparam int CMT_W   = 2;
  localparam int AREG_W  = 5;
  localparam int PREG_W  = 6;
  localparam int PC_W    = 32;
  localparam int ECODE_W = 6;
  localparam int IDX_W   = (CMT_W > 1) ? $clog2(CMT_W) : 1;

  typedef struct packed {
    logic            valid;
    logic            excp_v;
    logic            br_redir;
    logic            ertn;
    logic            replay;
    logic            idle;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] br_tgt;
  } CmtEvtSt;

  typedef struct packed {
    CmtEvtSt            evt;
    logic [AREG_W-1:0]  areg;
    logic [PREG_W-1:0]  preg;
    logic [PREG_W-1:0]  opreg;
    logic               opreg_v;
    logic [ECODE_W-1:0] ecode;
    logic               br;
    logic               br_taken;
  } CmtSlotSt;

  typedef enum logic [2:0] {
    CAUSE_EXCP,
    CAUSE_ERTN,
    CAUSE_BR,
    CAUSE_REPLAY,
    CAUSE_IDLE
  } FlushCauseE;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_IDLE_WAIT
  } CmtStateE;

  function automatic logic is_event(CmtEvtSt e);
    return e.valid & (e.excp_v | e.br_redir | e.ertn
                      | e.replay | e.idle);
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB -> commit retiring-entry bundle.
// master = reorder buffer, slave = commit stage.
interface commit_unit_if;
  import commit_unit_pkg::*;

  logic [CMT_W-1:0]         cmt_valid_i;
  logic [CMT_W*PC_W-1:0]    cmt_pc_i;
  logic [CMT_W*AREG_W-1:0]  cmt_areg_i;
  logic [CMT_W*PREG_W-1:0]  cmt_preg_i;
  logic [CMT_W*PREG_W-1:0]  cmt_opreg_i;
  logic [CMT_W-1:0]         cmt_opreg_v_i;
  logic [CMT_W-1:0]         cmt_excp_v_i;
  logic [CMT_W*ECODE_W-1:0] cmt_ecode_i;
  logic [CMT_W-1:0]         cmt_br_i;
  logic [CMT_W-1:0]         cmt_br_taken_i;
  logic [CMT_W-1:0]         cmt_br_redir_i;
  logic [CMT_W*PC_W-1:0]    cmt_br_tgt_i;
  logic [CMT_W-1:0]         cmt_ertn_i;
  logic [CMT_W-1:0]         cmt_replay_i;
  logic [CMT_W-1:0]         cmt_idle_i;

  modport master (
    output cmt_valid_i, cmt_pc_i, cmt_areg_i,
    output cmt_preg_i, cmt_opreg_i, cmt_opreg_v_i,
    output cmt_excp_v_i, cmt_ecode_i, cmt_br_i,
    output cmt_br_taken_i, cmt_br_redir_i,
    output cmt_br_tgt_i, cmt_ertn_i,
    output cmt_replay_i, cmt_idle_i
  );

  modport slave (
    input cmt_valid_i, cmt_pc_i, cmt_areg_i,
    input cmt_preg_i, cmt_opreg_i, cmt_opreg_v_i,
    input cmt_excp_v_i, cmt_ecode_i, cmt_br_i,
    input cmt_br_taken_i, cmt_br_redir_i,
    input cmt_br_tgt_i, cmt_ertn_i,
    input cmt_replay_i, cmt_idle_i
  );

endinterface

// File: rtl/commit_redirect_sel.sv
// commit_redirect_sel: finds the oldest event slot, marks
// the kept slots and picks the fetch restart PC by cause.
module commit_redirect_sel
  import commit_unit_pkg::*;
(
  input  CmtEvtSt          evt_i [CMT_W],
  input  logic [PC_W-1:0]  eentry_i,
  input  logic [PC_W-1:0]  era_i,
  output logic             evt_v_o,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic [CMT_W-1:0] keep_o,
  output FlushCauseE       cause_o,
  output logic [PC_W-1:0]  redir_pc_o
);

  CmtEvtSt sel;

  // oldest event wins; anything younger is squashed
  always_comb begin
    evt_v_o   = 1'b0;
    evt_idx_o = '0;
    keep_o    = '0;
    sel       = '0;
    for (int i = 0; i < CMT_W; i++) begin
      keep_o[i] = evt_i[i].valid & ~evt_v_o;
      if (!evt_v_o && is_event(evt_i[i])) begin
        evt_v_o   = 1'b1;
        evt_idx_o = IDX_W'(i);
        sel       = evt_i[i];
      end
    end
  end

  // restart target by cause priority
  always_comb begin
    cause_o    = CAUSE_EXCP;
    redir_pc_o = '0;
    if (sel.valid) begin
      priority case (1'b1)
        sel.excp_v: begin
          cause_o    = CAUSE_EXCP;
          redir_pc_o = eentry_i;
        end
        sel.ertn: begin
          cause_o    = CAUSE_ERTN;
          redir_pc_o = era_i;
        end
        sel.br_redir: begin
          cause_o    = CAUSE_BR;
          redir_pc_o = sel.br_tgt;
        end
        sel.replay: begin
          cause_o    = CAUSE_REPLAY;
          redir_pc_o = sel.pc + PC_W'(4);
        end
        sel.idle: begin
          cause_o    = CAUSE_IDLE;
          redir_pc_o = sel.pc + PC_W'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/commit_unit.sv
// commit_unit: retire stage after the ROB (RAT, free list,
// BPU, flush/redirect, IDLE). COMMIT_PERF_CNT_EN adds counters.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  commit_unit_if.slave            cmt,
  input  logic [PC_W-1:0]         csr_eentry_i,
  input  logic [PC_W-1:0]         csr_era_i,
  input  logic                    intr_i,
  output logic [CMT_W-1:0]        arat_we_o,
  output logic [CMT_W*AREG_W-1:0] arat_areg_o,
  output logic [CMT_W*PREG_W-1:0] arat_preg_o,
  output logic [CMT_W-1:0]        free_v_o,
  output logic [CMT_W*PREG_W-1:0] free_preg_o,
  output logic                    bpu_v_o,
  output logic [PC_W-1:0]         bpu_pc_o,
  output logic [PC_W-1:0]         bpu_tgt_o,
  output logic                    bpu_taken_o,
  output logic                    bpu_mispred_o,
  output logic                    flush_o,
  output logic [PC_W-1:0]         redir_pc_o,
  output logic                    excp_v_o,
  output logic [ECODE_W-1:0]      excp_code_o,
  output logic [PC_W-1:0]         excp_pc_o,
  output logic                    ertn_o,
  output logic                    idle_o
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]             instr_cnt_o,
  output logic [63:0]             redir_cnt_o,
  output logic [63:0]             excp_cnt_o
`endif
);

  CmtStateE         state_q, state_d;
  logic             idle_pend_q, idle_pend_d;
  CmtSlotSt         slot_q [CMT_W];
  CmtSlotSt         slot_d [CMT_W];
  CmtEvtSt          evt_view [CMT_W];
  logic             evt_v;
  logic [IDX_W-1:0] evt_idx;
  logic [CMT_W-1:0] keep;
  FlushCauseE       cause;
  logic [PC_W-1:0]  redir_pc;
  logic             run, flush, cap_en;

  assign run    = state_q == ST_RUN;
  assign flush  = run & evt_v;
  assign cap_en = run & ~evt_v;

  // unpack the bundle; younger entries are ignored while flushing
  always_comb begin
    for (int i = 0; i < CMT_W; i++) begin
      slot_d[i].evt.valid    = cmt.cmt_valid_i[i] & cap_en;
      slot_d[i].evt.excp_v   = cmt.cmt_excp_v_i[i];
      slot_d[i].evt.br_redir = cmt.cmt_br_redir_i[i];
      slot_d[i].evt.ertn     = cmt.cmt_ertn_i[i];
      slot_d[i].evt.replay   = cmt.cmt_replay_i[i];
      slot_d[i].evt.idle     = cmt.cmt_idle_i[i];
      slot_d[i].evt.pc       = cmt.cmt_pc_i[i*PC_W +: PC_W];
      slot_d[i].evt.br_tgt   = cmt.cmt_br_tgt_i[i*PC_W +: PC_W];
      slot_d[i].areg     = cmt.cmt_areg_i[i*AREG_W +: AREG_W];
      slot_d[i].preg     = cmt.cmt_preg_i[i*PREG_W +: PREG_W];
      slot_d[i].opreg    = cmt.cmt_opreg_i[i*PREG_W +: PREG_W];
      slot_d[i].opreg_v  = cmt.cmt_opreg_v_i[i];
      slot_d[i].ecode    = cmt.cmt_ecode_i[i*ECODE_W +: ECODE_W];
      slot_d[i].br       = cmt.cmt_br_i[i];
      slot_d[i].br_taken = cmt.cmt_br_taken_i[i];
      evt_view[i]        = slot_q[i].evt;
    end
  end

  // retiring-slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CMT_W; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < CMT_W; i++) slot_q[i] <= slot_d[i];
    end
  end

  commit_redirect_sel u_sel (
    .evt_i      (evt_view),
    .eentry_i   (csr_eentry_i),
    .era_i      (csr_era_i),
    .evt_v_o    (evt_v),
    .evt_idx_o  (evt_idx),
    .keep_o     (keep),
    .cause_o    (cause),
    .redir_pc_o (redir_pc)
  );

  // RAT update and old-preg release for kept, non-excepting slots
  always_comb begin
    arat_we_o   = '0;
    free_v_o    = '0;
    arat_areg_o = '0;
    arat_preg_o = '0;
    free_preg_o = '0;
    for (int i = 0; i < CMT_W; i++) begin
      arat_we_o[i] = run & keep[i] & slot_q[i].opreg_v
                     & ~slot_q[i].evt.excp_v;
      free_v_o[i]  = arat_we_o[i];
      arat_areg_o[i*AREG_W +: AREG_W] = slot_q[i].areg;
      arat_preg_o[i*PREG_W +: PREG_W] = slot_q[i].preg;
      free_preg_o[i*PREG_W +: PREG_W] = slot_q[i].opreg;
    end
  end

  // one BPU update per cycle from the oldest kept branch
  always_comb begin
    bpu_v_o       = 1'b0;
    bpu_pc_o      = '0;
    bpu_tgt_o     = '0;
    bpu_taken_o   = 1'b0;
    bpu_mispred_o = 1'b0;
    for (int i = 0; i < CMT_W; i++) begin
      if (!bpu_v_o && run && keep[i] && slot_q[i].br) begin
        bpu_v_o       = 1'b1;
        bpu_pc_o      = slot_q[i].evt.pc;
        bpu_tgt_o     = slot_q[i].evt.br_tgt;
        bpu_taken_o   = slot_q[i].br_taken;
        bpu_mispred_o = slot_q[i].evt.br_redir;
      end
    end
  end

  // flush, redirect and CSR event pulses
  always_comb begin
    flush_o     = flush;
    redir_pc_o  = flush ? redir_pc : '0;
    excp_v_o    = flush && (cause == CAUSE_EXCP);
    excp_code_o = excp_v_o ? slot_q[evt_idx].ecode : '0;
    excp_pc_o   = excp_v_o ? slot_q[evt_idx].evt.pc : '0;
    ertn_o      = flush && (cause == CAUSE_ERTN);
    idle_o      = state_q == ST_IDLE_WAIT;
  end

  // next-state: RUN -> FLUSH on event, FLUSH -> RUN/IDLE_WAIT
  always_comb begin
    state_d     = state_q;
    idle_pend_d = idle_pend_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d     = ST_FLUSH;
          idle_pend_d = cause == CAUSE_IDLE;
        end
      end
      ST_FLUSH: begin
        state_d     = idle_pend_q ? ST_IDLE_WAIT : ST_RUN;
        idle_pend_d = 1'b0;
      end
      ST_IDLE_WAIT: begin
        if (intr_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      idle_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_pend_q <= idle_pend_d;
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [IDX_W:0] n_ret;

  // retired-instruction count for this cycle
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < CMT_W; i++) begin
      n_ret = n_ret + (IDX_W+1)'(run & keep[i]
                      & ~slot_q[i].evt.excp_v);
    end
  end

  // free-running wrap-around counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_o <= '0;
      redir_cnt_o <= '0;
      excp_cnt_o  <= '0;
    end else begin
      instr_cnt_o <= instr_cnt_o + 64'(n_ret);
      redir_cnt_o <= redir_cnt_o + 64'(flush);
      excp_cnt_o  <= excp_cnt_o + 64'(excp_v_o);
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: table-driven vectors for commit_unit plus
// hand sequences for flush, IDLE wake-up and async reset.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_unit_if cif ();

  logic [31:0] eentry, era;
  logic        intr;
  logic [1:0]  arat_we, free_v;
  logic [9:0]  arat_areg;
  logic [11:0] arat_preg, free_preg;
  logic        bpu_v, bpu_taken, bpu_mis;
  logic [31:0] bpu_pc, bpu_tgt;
  logic        flush;
  logic [31:0] redir_pc;
  logic        excp_v, ertn, idle;
  logic [5:0]  excp_code;
  logic [31:0] excp_pc;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] instr_cnt, redir_cnt, excp_cnt;
`endif

  commit_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmt           (cif),
    .csr_eentry_i  (eentry),
    .csr_era_i     (era),
    .intr_i        (intr),
    .arat_we_o     (arat_we),
    .arat_areg_o   (arat_areg),
    .arat_preg_o   (arat_preg),
    .free_v_o      (free_v),
    .free_preg_o   (free_preg),
    .bpu_v_o       (bpu_v),
    .bpu_pc_o      (bpu_pc),
    .bpu_tgt_o     (bpu_tgt),
    .bpu_taken_o   (bpu_taken),
    .bpu_mispred_o (bpu_mis),
    .flush_o       (flush),
    .redir_pc_o    (redir_pc),
    .excp_v_o      (excp_v),
    .excp_code_o   (excp_code),
    .excp_pc_o     (excp_pc),
    .ertn_o        (ertn),
    .idle_o        (idle)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .instr_cnt_o   (instr_cnt),
    .redir_cnt_o   (redir_cnt),
    .excp_cnt_o    (excp_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]  v, opv, ex, br, tk, rd, er, rp, id;
    logic [63:0] pc, tgt;
    logic [11:0] opr, ec;
    logic [1:0]  e_we;
    logic        e_fl;
    logic [31:0] e_rpc;
    logic        e_bpu, e_tk, e_mis;
    logic [31:0] e_bpc, e_btg;
    logic        e_ex;
    logic [5:0]  e_ec;
    logic [31:0] e_epc;
    logic        e_er;
  } vec_t;

  vec_t vt[$];
  vec_t t;
  int   errs = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t a);
    cif.cmt_valid_i    = a.v;
    cif.cmt_pc_i       = a.pc;
    cif.cmt_areg_i     = {5'd4, 5'd3};
    cif.cmt_preg_i     = {6'd11, 6'd10};
    cif.cmt_opreg_i    = a.opr;
    cif.cmt_opreg_v_i  = a.opv;
    cif.cmt_excp_v_i   = a.ex;
    cif.cmt_ecode_i    = a.ec;
    cif.cmt_br_i       = a.br;
    cif.cmt_br_taken_i = a.tk;
    cif.cmt_br_redir_i = a.rd;
    cif.cmt_br_tgt_i   = a.tgt;
    cif.cmt_ertn_i     = a.er;
    cif.cmt_replay_i   = a.rp;
    cif.cmt_idle_i     = a.id;
  endtask

  task automatic clr();
    vec_t z;
    z = '0;
    apply(z);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t alu_vec();
    vec_t a;
    a = '0;
    a.v = 2'b11; a.opv = 2'b11;
    a.opr = {6'd9, 6'd7};
    a.pc = {32'h1c000004, 32'h1c000000};
    a.e_we = 2'b11;
    return a;
  endfunction

  function automatic vec_t idle_vec();
    vec_t a;
    a = '0;
    a.v = 2'b01; a.id = 2'b01;
    a.pc = {32'h0, 32'hfffffffc};
    return a;
  endfunction

  initial begin
    eentry = 32'h1c008000;
    era    = 32'h1c002000;
    intr   = 1'b0;
    clr();

    vt.push_back(alu_vec());
    t = '0; t.v = 2'b11; t.opv = 2'b10; t.br = 2'b01;
    t.tk = 2'b01; t.rd = 2'b01;
    t.pc = {32'h1c0000f4, 32'h1c0000f0};
    t.tgt = {32'h0, 32'h1c000100};
    t.e_fl = 1; t.e_rpc = 32'h1c000100; t.e_bpu = 1;
    t.e_tk = 1; t.e_mis = 1; t.e_bpc = 32'h1c0000f0;
    t.e_btg = 32'h1c000100;
    vt.push_back(t);
    t = '0; t.v = 2'b01; t.ex = 2'b01; t.opv = 2'b01;
    t.ec = {6'h0, 6'h09}; t.pc = {32'h0, 32'h1c000040};
    t.e_fl = 1; t.e_rpc = 32'h1c008000; t.e_ex = 1;
    t.e_ec = 6'h09; t.e_epc = 32'h1c000040;
    vt.push_back(t);
    t = '0; t.v = 2'b11; t.opv = 2'b01; t.er = 2'b10;
    t.pc = {32'h1c000504, 32'h1c000500};
    t.e_we = 2'b01; t.e_fl = 1; t.e_rpc = 32'h1c002000;
    t.e_er = 1;
    vt.push_back(t);
    t = '0; t.v = 2'b11; t.br = 2'b11; t.tk = 2'b01;
    t.pc = {32'h1c000204, 32'h1c000200};
    t.tgt = {32'h1c000300, 32'h1c000280};
    t.e_bpu = 1; t.e_tk = 1; t.e_bpc = 32'h1c000200;
    t.e_btg = 32'h1c000280;
    vt.push_back(t);
    t = '0; t.v = 2'b11; t.opv = 2'b11; t.rp = 2'b01;
    t.opr = {6'd3, 6'd2};
    t.pc = {32'h1c000304, 32'h1c000300};
    t.e_we = 2'b01; t.e_fl = 1; t.e_rpc = 32'h1c000304;
    vt.push_back(t);
    t = '0; t.v = 2'b11; t.opv = 2'b11; t.ex = 2'b10;
    t.opr = {6'd5, 6'd4}; t.ec = {6'h0b, 6'h0};
    t.pc = {32'h1c000404, 32'h1c000400};
    t.e_we = 2'b01; t.e_fl = 1; t.e_rpc = 32'h1c008000;
    t.e_ex = 1; t.e_ec = 6'h0b; t.e_epc = 32'h1c000404;
    vt.push_back(t);
    t = '0; t.v = 2'b11; t.opv = 2'b01; t.br = 2'b10;
    t.opr = {6'd0, 6'd12};
    t.pc = {32'h1c000604, 32'h1c000600};
    t.tgt = {32'h1c000700, 32'h0};
    t.e_we = 2'b01; t.e_bpu = 1;
    t.e_bpc = 32'h1c000604; t.e_btg = 32'h1c000700;
    vt.push_back(t);
    t = '0;
    vt.push_back(t);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", arat_we, 0);
    chk("rst_free", free_v, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redir_pc, 0);
    chk("rst_bpu", bpu_v, 0);
    chk("rst_excp", {excp_v, ertn, idle}, 0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < vt.size(); k++) begin
      t = vt[k];
      apply(t);
      step();
      chk($sformatf("v%0d_we", k), arat_we, t.e_we);
      chk($sformatf("v%0d_free", k), free_v, t.e_we);
      for (int s = 0; s < 2; s++)
        if (t.e_we[s])
          chk($sformatf("v%0d_fpreg%0d", k, s),
              free_preg[s*6 +: 6], t.opr[s*6 +: 6]);
      chk($sformatf("v%0d_flush", k), flush, t.e_fl);
      chk($sformatf("v%0d_redir", k), redir_pc, t.e_rpc);
      chk($sformatf("v%0d_bpu", k), bpu_v, t.e_bpu);
      if (t.e_bpu) begin
        chk($sformatf("v%0d_bpc", k), bpu_pc, t.e_bpc);
        chk($sformatf("v%0d_btg", k), bpu_tgt, t.e_btg);
        chk($sformatf("v%0d_btk", k), bpu_taken, t.e_tk);
        chk($sformatf("v%0d_bmis", k), bpu_mis, t.e_mis);
      end
      chk($sformatf("v%0d_excp", k), excp_v, t.e_ex);
      if (t.e_ex) begin
        chk($sformatf("v%0d_ecode", k), excp_code, t.e_ec);
        chk($sformatf("v%0d_epc", k), excp_pc, t.e_epc);
      end
      chk($sformatf("v%0d_ertn", k), ertn, t.e_er);
      clr();
      step();
      if (t.e_fl) chk($sformatf("v%0d_1cyc", k), flush, 0);
      step();
      step();
    end

    // entries arriving during the flush are discarded
    apply(vt[1]);
    step();
    chk("sq_flush", flush, 1);
    apply(alu_vec());
    step();
    chk("sq_inflush_we", arat_we, 0);
    chk("sq_inflush_fl", flush, 0);
    step();
    chk("sq_after_we", arat_we, 0);
    step();
    chk("sq_resume_we", arat_we, 2'b11);
    clr();
    step();

    // IDLE with pc+4 wrap, wake on interrupt
    apply(idle_vec());
    step();
    chk("idle_flush", flush, 1);
    chk("idle_redir", redir_pc, 0);
    chk("idle_early", idle, 0);
    clr();
    step();
    chk("idle_fl_st", idle, 0);
    step();
    chk("idle_on", idle, 1);
    apply(alu_vec());
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("idle_hold%0d", c), idle, 1);
      chk($sformatf("idle_we%0d", c), arat_we, 0);
    end
    intr = 1'b1;
    step();
    intr = 1'b0;
    chk("idle_wake", idle, 0);
    chk("idle_wake_we", arat_we, 0);
    step();
    chk("idle_run_we", arat_we, 2'b11);
    clr();
    step();

    // interrupt already pending with the idle event
    apply(idle_vec());
    intr = 1'b1;
    step();
    chk("ii_flush", flush, 1);
    clr();
    step();
    chk("ii_fl_st", idle, 0);
    step();
    chk("ii_one", idle, 1);
    step();
    chk("ii_out", idle, 0);
    intr = 1'b0;
    step();

    // async reset while waiting in IDLE
    apply(idle_vec());
    step();
    clr();
    step();
    step();
    chk("rs_idle", idle, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_idle", idle, 0);
    chk("rs_async_fl", {flush, excp_v, ertn}, 0);
    step();
    rst_n = 1'b1;
    apply(alu_vec());
    step();
    chk("rs_run_we", arat_we, 2'b11);
    chk("rs_run_idle", idle, 0);
    clr();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
